// File: rtl/mem_arbiter.sv
// Two-master round-robin data-memory arbiter with ownership lock and read-tag return.
// Optional grant/conflict statistics are built when MEM_ARB_STATS_EN is defined.
module mem_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_HOLD     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic        m0_lock,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic        m1_lock,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_w_enable,
  output logic        mem_r_enable,
  input  logic [31:0] mem_rdata,
  output logic [31:0] stat_gnt0,
  output logic [31:0] stat_gnt1,
  output logic [31:0] stat_conflict
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_t;

  localparam logic [8:0] HOLD_MAX = 9'(MAX_HOLD);
  localparam int         LAST     = READ_LATENCY - 1;

  state_t     state;
  logic       rr_ptr;
  logic [7:0] hold_cnt;
  logic [8:0] hold_inc;
  logic       hold_done;
  logic       gnt0;
  logic       gnt1;
  logic       win_lock;

  logic [READ_LATENCY-1:0] tag_v;
  logic [READ_LATENCY-1:0] tag_id;

  assign hold_inc  = {1'b0, hold_cnt} + 9'd1;
  assign hold_done = (hold_inc >= HOLD_MAX);
  assign win_lock  = (gnt0 & m0_lock) | (gnt1 & m1_lock);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (reset_n) begin
      unique case (state)
        OWN0: begin
          gnt0 = m0_req;
          gnt1 = ~m0_req & m1_req;
        end
        OWN1: begin
          gnt1 = m1_req;
          gnt0 = ~m1_req & m0_req;
        end
        default: begin
          gnt0 = m0_req & (~m1_req | ~rr_ptr);
          gnt1 = m1_req & ~gnt0;
        end
      endcase
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  always_comb begin
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_w_enable = 1'b0;
    mem_r_enable = 1'b0;
    unique case (1'b1)
      gnt0: begin
        mem_addr     = m0_addr;
        mem_wdata    = m0_wdata;
        mem_w_enable = m0_we;
        mem_r_enable = ~m0_we;
      end
      gnt1: begin
        mem_addr     = m1_addr;
        mem_wdata    = m1_wdata;
        mem_w_enable = m1_we;
        mem_r_enable = ~m1_we;
      end
      default: begin
        mem_addr = '0;
      end
    endcase
  end

  // Owner keeps priority; other master fills owner's idle cycles without state change.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      hold_cnt <= '0;
    end else begin
      unique case (state)
        OWN0: begin
          if (gnt0) begin
            if (hold_done) begin
              state    <= IDLE;
              hold_cnt <= '0;
              rr_ptr   <= 1'b1;
            end else if (!m0_lock) begin
              state    <= IDLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_inc[7:0];
            end
          end else if (!gnt1) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        end
        OWN1: begin
          if (gnt1) begin
            if (hold_done) begin
              state    <= IDLE;
              hold_cnt <= '0;
              rr_ptr   <= 1'b0;
            end else if (!m1_lock) begin
              state    <= IDLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_inc[7:0];
            end
          end else if (!gnt0) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end
        end
        default: begin
          if (m0_req && m1_req) begin
            rr_ptr <= gnt0;
          end
          if (win_lock) begin
            if (MAX_HOLD > 1) begin
              state    <= gnt0 ? OWN0 : OWN1;
              hold_cnt <= 8'd1;
            end else begin
              rr_ptr <= gnt0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= mem_r_enable;
      tag_id[0] <= gnt1;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  assign m0_rvalid = tag_v[LAST] & ~tag_id[LAST];
  assign m1_rvalid = tag_v[LAST] & tag_id[LAST];
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] cnt_g0;
  logic [31:0] cnt_g1;
  logic [31:0] cnt_cf;

  // Saturating counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_g0 <= '0;
      cnt_g1 <= '0;
      cnt_cf <= '0;
    end else begin
      if (gnt0 && cnt_g0 != '1) cnt_g0 <= cnt_g0 + 32'd1;
      if (gnt1 && cnt_g1 != '1) cnt_g1 <= cnt_g1 + 32'd1;
      if (m0_req && m1_req && cnt_cf != '1) cnt_cf <= cnt_cf + 32'd1;
    end
  end

  assign stat_gnt0     = cnt_g0;
  assign stat_gnt1     = cnt_g1;
  assign stat_conflict = cnt_cf;
`else
  assign stat_gnt0     = '0;
  assign stat_gnt1     = '0;
  assign stat_conflict = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, reset corner,
// statistics sequence and randomized traffic against a reference model.
module tb_mem_arbiter;

  localparam int LAT  = 1;
  localparam int HOLD = 8;
  localparam logic [31:0] HASH = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_req = 0, m0_we = 0, m0_lock = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0;
  logic        m1_req = 0, m1_we = 0, m1_lock = 0;
  logic [31:0] m1_addr = 0, m1_wdata = 0;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_w_enable, mem_r_enable;
  logic [31:0] mem_rdata;
  logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.READ_LATENCY(LAT), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_w_enable(mem_w_enable), .mem_r_enable(mem_r_enable),
    .mem_rdata(mem_rdata),
    .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1),
    .stat_conflict(stat_conflict)
  );

  always #5 clk = ~clk;

  // Synchronous memory: returns a hash of the address read one cycle later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) mem_rdata <= '0;
    else if (mem_r_enable) mem_rdata <= mem_addr ^ HASH;
  end

  typedef struct {
    logic        r0, w0, l0;
    logic [31:0] a0, d0;
    logic        r1, w1, l1;
    logic [31:0] a1, d1;
    logic [3:0]  exp;
  } vec_t;

  typedef struct {
    bit          v;
    bit          id;
    logic [31:0] a;
  } tag_t;

  int          own;
  int          rr;
  int          hold;
  tag_t        pipe[$];
  logic [31:0] sg0, sg1, scf;

  task automatic model_reset();
    own = -1;
    rr = 0;
    hold = 0;
    pipe.delete();
    sg0 = 0;
    sg1 = 0;
    scf = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit r0, input bit w0, input bit l0,
                              input logic [31:0] a0, input bit r1,
                              input bit w1, input bit l1,
                              input logic [31:0] a1, input logic [3:0] e);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = ~a0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = 32'hDEADBEEF;
    v.exp = e;
    return v;
  endfunction

  task automatic step(input vec_t v, input bit use_exp, output int g);
    bit          rq[2], wq[2], lk[2];
    logic [31:0] ad[2], wd[2];
    tag_t        e, t;
    logic [31:0] ea, ew;
    @(negedge clk);
    m0_req = v.r0; m0_we = v.w0; m0_lock = v.l0;
    m0_addr = v.a0; m0_wdata = v.d0;
    m1_req = v.r1; m1_we = v.w1; m1_lock = v.l1;
    m1_addr = v.a1; m1_wdata = v.d1;
    #1;
    rq[0] = v.r0; wq[0] = v.w0; lk[0] = v.l0; ad[0] = v.a0; wd[0] = v.d0;
    rq[1] = v.r1; wq[1] = v.w1; lk[1] = v.l1; ad[1] = v.a1; wd[1] = v.d1;
    if (own >= 0) g = rq[own] ? own : (rq[1-own] ? 1 - own : -1);
    else if (rq[0] && rq[1]) g = rr;
    else if (rq[0]) g = 0;
    else if (rq[1]) g = 1;
    else g = -1;
    e = '{v: 0, id: 0, a: 0};
    if (pipe.size() == LAT) e = pipe.pop_front();
    ea = (g >= 0) ? ad[g] : 32'd0;
    ew = (g >= 0) ? wd[g] : 32'd0;
    chk("gnt0", {31'd0, m0_gnt}, {31'd0, g == 0});
    chk("gnt1", {31'd0, m1_gnt}, {31'd0, g == 1});
    chk("mem_addr", mem_addr, ea);
    chk("mem_wdata", mem_wdata, ew);
    chk("mem_we", {31'd0, mem_w_enable}, {31'd0, g >= 0 && wq[g]});
    chk("mem_re", {31'd0, mem_r_enable}, {31'd0, g >= 0 && !wq[g]});
    chk("rvalid0", {31'd0, m0_rvalid}, {31'd0, e.v && !e.id});
    chk("rvalid1", {31'd0, m1_rvalid}, {31'd0, e.v && e.id});
    chk("rdata0", m0_rdata, (e.v && !e.id) ? (e.a ^ HASH) : 32'd0);
    chk("rdata1", m1_rdata, (e.v && e.id) ? (e.a ^ HASH) : 32'd0);
`ifdef MEM_ARB_STATS_EN
    chk("stat_gnt0", stat_gnt0, sg0);
    chk("stat_gnt1", stat_gnt1, sg1);
    chk("stat_conflict", stat_conflict, scf);
`else
    chk("stat_gnt0", stat_gnt0, 32'd0);
    chk("stat_gnt1", stat_gnt1, 32'd0);
    chk("stat_conflict", stat_conflict, 32'd0);
`endif
    if (use_exp)
      chk("vec_g0g1rv0rv1", {28'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid},
          {28'd0, v.exp});
    if (own < 0) begin
      if (rq[0] && rq[1]) rr = 1 - g;
      if (g >= 0 && lk[g]) begin
        if (HOLD > 1) begin
          own = g;
          hold = 1;
        end else begin
          rr = 1 - g;
        end
      end
    end else if (g == own) begin
      hold++;
      if (hold >= HOLD) begin
        rr = 1 - own;
        own = -1;
        hold = 0;
      end else if (!lk[own]) begin
        own = -1;
        hold = 0;
      end
    end else if (g < 0) begin
      own = -1;
      hold = 0;
    end
    t.v = (g >= 0) && !wq[g];
    t.id = (g == 1);
    t.a = ea;
    pipe.push_back(t);
    if (g == 0) sg0++;
    if (g == 1) sg1++;
    if (rq[0] && rq[1]) scf++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    m0_req = 0; m1_req = 0; m0_lock = 0; m1_lock = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_n = 1;
  endtask

  vec_t tbl[30];
  vec_t idle;
  vec_t rv;
  int   n;
  int   g;
  bit   have[2];
  vec_t pend;

  initial begin
    model_reset();
    n = 0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0000);
    tbl[n++] = mk(1, 0, 0, 32'h10, 0, 0, 0, 0, 4'b1000);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0010);
    tbl[n++] = mk(1, 0, 0, 32'h100, 1, 0, 0, 32'h200, 4'b1000);
    tbl[n++] = mk(1, 0, 0, 32'h100, 1, 0, 0, 32'h200, 4'b0110);
    tbl[n++] = mk(1, 0, 0, 32'h100, 1, 0, 0, 32'h200, 4'b1001);
    tbl[n++] = mk(1, 0, 0, 32'h100, 1, 0, 0, 32'h200, 4'b0110);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
    tbl[n++] = mk(0, 0, 0, 0, 1, 1, 1, 32'h20, 4'b0100);
    for (int i = 0; i < 7; i++)
      tbl[n++] = mk(1, 0, 0, 32'h30, 1, 1, 1, 32'h20, 4'b0100);
    tbl[n++] = mk(1, 0, 0, 32'h30, 1, 1, 1, 32'h20, 4'b1000);
    tbl[n++] = mk(1, 0, 0, 32'h30, 1, 1, 0, 32'h20, 4'b0110);
    tbl[n++] = mk(1, 0, 0, 32'h40, 1, 0, 0, 32'h50, 4'b1000);
    tbl[n++] = mk(1, 0, 1, 32'h40, 0, 0, 0, 32'h50, 4'b1010);
    tbl[n++] = mk(1, 0, 1, 32'h40, 1, 0, 0, 32'h50, 4'b1010);
    tbl[n++] = mk(0, 0, 0, 32'h40, 1, 0, 0, 32'h50, 4'b0110);
    tbl[n++] = mk(1, 0, 1, 32'h44, 1, 0, 0, 32'h54, 4'b1001);
    tbl[n++] = mk(1, 0, 0, 32'h44, 1, 0, 0, 32'h54, 4'b1010);
    tbl[n++] = mk(1, 0, 0, 32'h48, 1, 0, 0, 32'h54, 4'b0110);
    tbl[n++] = mk(1, 0, 1, 32'h48, 1, 0, 1, 32'h58, 4'b1001);
    tbl[n++] = mk(1, 0, 1, 32'h4C, 1, 0, 1, 32'h58, 4'b1010);
    tbl[n++] = mk(0, 0, 0, 32'h4C, 1, 0, 1, 32'h58, 4'b0110);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001);
    tbl[n++] = mk(1, 0, 0, 32'h60, 1, 0, 0, 32'h64, 4'b0100);
    tbl[n++] = mk(0, 0, 0, 0, 0, 0, 0, 0, 4'b0001);

    do_reset();
    for (int i = 0; i < n; i++) step(tbl[i], 1'b1, g);

    step(mk(1, 0, 0, 32'h70, 0, 0, 0, 0, 4'b1000), 1'b1, g);
    @(negedge clk);
    reset_n = 0;
    m0_req = 1; m0_we = 0; m1_req = 1; m1_we = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("rst_gnt", {30'd0, m0_gnt, m1_gnt}, 32'd0);
      chk("rst_en", {30'd0, mem_r_enable, mem_w_enable}, 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
      chk("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      chk("rst_stats", stat_gnt0 | stat_gnt1 | stat_conflict, 32'd0);
      @(negedge clk);
    end
    model_reset();
    m0_req = 0; m1_req = 0;
    reset_n = 1;
    for (int i = 0; i < 3; i++) step(idle, 1'b1, g);

    do_reset();
    step(mk(1, 0, 0, 32'h80, 1, 0, 0, 32'h90, 4'b1000), 1'b1, g);
    step(mk(1, 0, 0, 32'h80, 1, 0, 0, 32'h90, 4'b0110), 1'b1, g);
    step(mk(1, 0, 0, 32'h84, 1, 0, 0, 32'h90, 4'b1001), 1'b1, g);
    step(mk(1, 0, 0, 32'h84, 1, 0, 0, 32'h94, 4'b0110), 1'b1, g);
    step(mk(1, 0, 0, 32'h88, 1, 0, 0, 32'h94, 4'b1001), 1'b1, g);
    step(idle, 1'b0, g);
`ifdef MEM_ARB_STATS_EN
    chk("stats_conflict5", stat_conflict, 32'd5);
    chk("stats_gnt0_3", stat_gnt0, 32'd3);
    chk("stats_gnt1_2", stat_gnt1, 32'd2);
`else
    chk("stats_conflict0", stat_conflict, 32'd0);
    chk("stats_gnt0_0", stat_gnt0, 32'd0);
    chk("stats_gnt1_0", stat_gnt1, 32'd0);
`endif

    have[0] = 0;
    have[1] = 0;
    pend = idle;
    for (int c = 0; c < 3000; c++) begin
      rv = mk($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3) != 0,
              $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
              $urandom_range(0, 3) != 0, $urandom, 4'b0000);
      if (!have[0]) begin
        pend.r0 = $urandom_range(0, 2) != 0;
        pend.w0 = rv.w0; pend.a0 = rv.a0; pend.d0 = rv.d0;
      end
      if (!have[1]) begin
        pend.r1 = $urandom_range(0, 2) != 0;
        pend.w1 = rv.w1; pend.a1 = rv.a1; pend.d1 = $urandom;
      end
      pend.l0 = rv.l0;
      pend.l1 = rv.l1;
      have[0] = pend.r0;
      have[1] = pend.r1;
      step(pend, 1'b0, g);
      if (g == 0) have[0] = 0;
      if (g == 1) have[1] = 0;
    end
    step(idle, 1'b0, g);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
